// File: rtl/csr_file.sv
// Machine-mode CSR file and trap-state holder for the core pipeline.
// Optional: define CSR_COUNTERS_EN to build mcycle/minstret and their user aliases.
package csr_pkg;
  typedef enum logic [1:0] {
    CSR_NONE       = 2'd0,
    CSR_READ_WRITE = 2'd1,
    CSR_SET        = 2'd2,
    CSR_CLR        = 2'd3
  } csr_op_mode_t;
endpackage

module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         csr_r_en_i,
  input  logic [11:0]  csr_addr_i,
  input  csr_op_mode_t csr_op_mode_i,
  input  logic [31:0]  csr_w_data_i,
  output logic [31:0]  csr_r_data_o,
  output logic         csr_exception_o,
  input  logic         trap_i,
  input  logic [31:0]  excep_code_i,
  input  logic         load_mcause_i,
  input  logic [31:0]  epc_i,
  input  logic         ret_i,
  input  logic         retire_i,
  output logic [31:0]  mtvec_o,
  output logic [31:0]  mepc_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;

  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic [31:0] mie_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;
  logic [31:0] r_data_reg;
  logic        exception_reg;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_reg;
  logic [63:0] minstret_reg;
`endif

  logic [31:0] mstatus_value;
  logic [31:0] old_value;
  logic [31:0] new_value;
  logic        implemented;
  logic        wants_write;
  logic        illegal;
  logic        do_write;

  assign mstatus_value = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};

  always_comb begin
    old_value   = 32'h0;
    implemented = 1'b1;
    case (csr_addr_i)
      ADDR_MSTATUS:   old_value = mstatus_value;
      ADDR_MISA:      old_value = MISA_VALUE;
      ADDR_MIE:       old_value = mie_reg;
      ADDR_MTVEC:     old_value = mtvec_reg;
      ADDR_MSCRATCH:  old_value = mscratch_reg;
      ADDR_MEPC:      old_value = mepc_reg;
      ADDR_MCAUSE:    old_value = mcause_reg;
      ADDR_MTVAL:     old_value = mtval_reg;
      ADDR_MHARTID:   old_value = HART_ID;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE, ADDR_CYCLE:       old_value = mcycle_reg[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH:     old_value = mcycle_reg[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:   old_value = minstret_reg[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: old_value = minstret_reg[63:32];
`endif
      default:        implemented = 1'b0;
    endcase
  end

  always_comb begin
    new_value = old_value;
    case (csr_op_mode_i)
      CSR_READ_WRITE: new_value = csr_w_data_i;
      CSR_SET:        new_value = old_value | csr_w_data_i;
      CSR_CLR:        new_value = old_value & ~csr_w_data_i;
      default:        new_value = old_value;
    endcase
  end

  // SET/CLR with a zero mask never writes, so they stay legal on read-only CSRs.
  assign wants_write = csr_r_en_i &&
                       ((csr_op_mode_i == CSR_READ_WRITE) ||
                        (((csr_op_mode_i == CSR_SET) || (csr_op_mode_i == CSR_CLR)) &&
                         (csr_w_data_i != 32'h0)));
  assign illegal     = csr_r_en_i &&
                       (!implemented ||
                        (wants_write && ((csr_addr_i[11:10] == 2'b11) || (csr_addr_i == ADDR_MISA))));
  assign do_write    = wants_write && !illegal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= 32'h0;
      mtvec_reg        <= MTVEC_RESET & ~32'h3;
      mscratch_reg     <= 32'h0;
      mepc_reg         <= 32'h0;
      mcause_reg       <= 32'h0;
      mtval_reg        <= 32'h0;
      r_data_reg       <= 32'h0;
      exception_reg    <= 1'b0;
    end else begin
      if (csr_r_en_i) begin
        r_data_reg <= illegal ? 32'h0 : old_value;
      end
      exception_reg <= illegal;

      if (do_write) begin
        case (csr_addr_i)
          ADDR_MSTATUS: begin
            mstatus_mie_reg  <= new_value[3];
            mstatus_mpie_reg <= new_value[7];
          end
          ADDR_MIE:      mie_reg      <= new_value;
          ADDR_MTVEC:    mtvec_reg    <= new_value & ~32'h3;
          ADDR_MSCRATCH: mscratch_reg <= new_value;
          ADDR_MEPC:     mepc_reg     <= new_value & ~32'h3;
          ADDR_MCAUSE:   mcause_reg   <= new_value;
          ADDR_MTVAL:    mtval_reg    <= new_value;
          default:       ;
        endcase
      end

      // Trap/return state updates come last so they win over a same-edge CSR write.
      if (trap_i) begin
        mepc_reg         <= epc_i & ~32'h3;
        mcause_reg       <= load_mcause_i ? {28'b0, excep_code_i[3:0]} : CAUSE_ILLEGAL;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (illegal) begin
        mepc_reg         <= epc_i & ~32'h3;
        mcause_reg       <= CAUSE_ILLEGAL;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (ret_i) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_next;
  logic [63:0] minstret_next;

  // A write to either half replaces it and skips that edge's increment.
  always_comb begin
    mcycle_next   = mcycle_reg + 64'd1;
    minstret_next = retire_i ? (minstret_reg + 64'd1) : minstret_reg;
    if (do_write && (csr_addr_i == ADDR_MCYCLE)) begin
      mcycle_next = {mcycle_reg[63:32], new_value};
    end else if (do_write && (csr_addr_i == ADDR_MCYCLEH)) begin
      mcycle_next = {new_value, mcycle_reg[31:0]};
    end
    if (do_write && (csr_addr_i == ADDR_MINSTRET)) begin
      minstret_next = {minstret_reg[63:32], new_value};
    end else if (do_write && (csr_addr_i == ADDR_MINSTRETH)) begin
      minstret_next = {new_value, minstret_reg[31:0]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_reg   <= 64'h0;
      minstret_reg <= 64'h0;
    end else begin
      mcycle_reg   <= mcycle_next;
      minstret_reg <= minstret_next;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^excep_code_i[31:4];
`else
  logic unused_inputs;
  assign unused_inputs = ^{excep_code_i[31:4], retire_i};
`endif

  assign csr_r_data_o    = r_data_reg;
  assign csr_exception_o = exception_reg;
  assign mtvec_o         = mtvec_reg;
  assign mepc_o          = mepc_reg;

endmodule
